// File: rtl/pe_rd_arbiter.sv
// pe_rd_arbiter: round-robin arbiter that lets N_REQ pe_controller requesters
// share one input-RAM read port in bursts.
//
// Ports:
//   aclk        clock, all state on the rising edge
//   areset      asynchronous active-high reset
//   req         per-requester burst request level
//   req_addr    per-requester burst start address, slice i = [i*AW +: AW]
//   req_len     per-requester beat count minus one, same slicing
//   gnt         one-hot grant, held from first beat through the drain cycle
//   mem_en      RAM read enable (high only while bursting)
//   mem_addr    RAM read address
//   mem_rddata  RAM read data, valid one cycle after its mem_en cycle
//   rd_data     mem_rddata broadcast to every requester
//   rd_valid    marks rd_data valid for the granted requester
//   burst_done  one-cycle pulse on the last data beat of a burst
module pe_rd_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned L_RAM_SIZE = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*(L_RAM_SIZE+1)-1:0] req_addr,
    input  logic [N_REQ*(L_RAM_SIZE+1)-1:0] req_len,
    output logic [N_REQ-1:0]           gnt,
    output logic                       mem_en,
    output logic [L_RAM_SIZE:0]        mem_addr,
    input  logic [DATA_W-1:0]          mem_rddata,
    output logic [DATA_W-1:0]          rd_data,
    output logic [N_REQ-1:0]           rd_valid,
    output logic [N_REQ-1:0]           burst_done
);

    localparam int unsigned AW = L_RAM_SIZE + 1;
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [AW-1:0]     base, base_nxt;
    logic [AW-1:0]     len_q, len_nxt;
    logic [AW-1:0]     cnt, cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic              mem_en_nxt;
    logic [AW-1:0]     mem_addr_nxt;
    logic [N_REQ-1:0]  done_nxt;

    logic [AW-1:0]     addr_arr [N_REQ];
    logic [AW-1:0]     len_arr  [N_REQ];
    logic              found;
    logic [PW-1:0]     win;

    // Unpack the flat per-requester address/length buses
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*AW +: AW];
        assign len_arr[g]  = req_len[g*AW +: AW];
    end

    // Read data is shared; rd_valid tells each requester whether it is theirs
    assign rd_data = mem_rddata;

    // Round-robin search starting at ptr, wrapping around
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            automatic logic [PW-1:0] idx = PW'((int'(ptr) + int'(k)) % int'(N_REQ));
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        base_nxt     = base;
        len_nxt      = len_q;
        cnt_nxt      = cnt;
        gnt_nxt      = gnt;
        mem_en_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        done_nxt     = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = BURST;
                    gnt_nxt      = N_REQ'(1) << win;
                    ptr_nxt      = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
                    base_nxt     = addr_arr[win];
                    len_nxt      = len_arr[win];
                    cnt_nxt      = '0;
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = addr_arr[win];
                end
            end
            BURST: begin
                if (cnt == len_q) begin
                    // Last read issued; its data returns in the drain cycle
                    state_nxt = DRAIN;
                    done_nxt  = gnt;
                end else begin
                    cnt_nxt      = cnt + AW'(1);
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = base + cnt_nxt;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr        <= '0;
            base       <= '0;
            len_q      <= '0;
            cnt        <= '0;
            gnt        <= '0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            rd_valid   <= '0;
            burst_done <= '0;
        end else begin
            ptr        <= ptr_nxt;
            base       <= base_nxt;
            len_q      <= len_nxt;
            cnt        <= cnt_nxt;
            gnt        <= gnt_nxt;
            mem_en     <= mem_en_nxt;
            mem_addr   <= mem_addr_nxt;
            rd_valid   <= mem_en ? gnt : '0;
            burst_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pe_rd_arbiter.sv
// Scoreboard testbench for pe_rd_arbiter: the stimulus side predicts the
// grant order and burst contents, the monitor checks returned beats.
module tb_pe_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            aclk;
    logic            areset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*AW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rddata;
    logic [DW-1:0]   rd_data;
    logic [N-1:0]    rd_valid;
    logic [N-1:0]    burst_done;

    pe_rd_arbiter #(.N_REQ(N), .L_RAM_SIZE(AW-1), .DATA_W(DW)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .req        (req),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .gnt        (gnt),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rddata (mem_rddata),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .burst_done (burst_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0]    w;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
    } burst_t;

    burst_t q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     m_ptr    = 0;

    // Monitor state
    bit     active = 0;
    burst_t cur;
    int     beat;
    logic   prev_me;
    logic [N-1:0] prev_g;

    function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
        return 32'hC0DE0000 ^ (32'(a) * 32'h00010101);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: one-cycle read latency
    always @(posedge aclk) begin
        if (mem_en) mem_rddata <= ram_f(mem_addr);
    end

    // Monitor: pops an expected burst on the first beat and checks every beat
    always @(negedge aclk) begin
        if (areset) begin
            active  = 0;
            prev_me = 1'b0;
            prev_g  = '0;
        end else begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("mem_en_needs_gnt", 32'(!mem_en || gnt != '0), 32'd1);
            check("rd_valid_timing", 32'(rd_valid), 32'(prev_me ? prev_g : '0));
            if (prev_g != '0 && gnt != '0)
                check("no_direct_regrant", 32'(gnt), 32'(prev_g));
            if (rd_valid != '0) begin
                if (!active) begin
                    if (q.size() == 0) begin
                        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
                    end else begin
                        cur    = q.pop_front();
                        active = 1;
                        beat   = 0;
                    end
                end
                if (active) begin
                    automatic logic [AW-1:0] ea = cur.addr + AW'(beat);
                    check("rd_valid_owner", 32'(rd_valid), 32'(4'b0001 << cur.w));
                    check("rd_data", rd_data, ram_f(ea));
                    check("burst_done", 32'(burst_done),
                          32'((beat == int'(cur.len)) ? rd_valid : '0));
                    if (beat == int'(cur.len)) active = 0;
                    beat++;
                end
            end else begin
                check("burst_done_idle", 32'(burst_done), 32'd0);
                if (active) begin
                    check("short_burst_beats", 32'(beat), 32'(cur.len) + 1);
                    active = 0;
                end
            end
            prev_me = mem_en;
            prev_g  = gnt;
        end
    end

    // Predict grant order for a fixed request set, then drive it
    task automatic run_round(input logic [N-1:0] mask, input logic [N*AW-1:0] addrs,
                             input logic [N*AW-1:0] lens, input bit chk_lat);
        logic [N-1:0] rem;
        int first_w;
        bit finished;
        rem     = mask;
        first_w = -1;
        while (rem != '0) begin
            int w;
            burst_t b;
            w = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && rem[idx]) w = idx;
            end
            if (first_w < 0) first_w = w;
            b.w    = 2'(w);
            b.addr = addrs[w*AW +: AW];
            b.len  = lens[w*AW +: AW];
            q.push_back(b);
            rem[w] = 1'b0;
            m_ptr  = (w + 1) % N;
        end
        req      = mask;
        req_addr = addrs;
        req_len  = lens;
        finished = 0;
        for (int c = 0; c < 500 && !finished; c++) begin
            @(negedge aclk);
            if (chk_lat && c == 0)
                check("grant_latency", 32'(gnt), 32'(4'b0001 << first_w));
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    // Drop req and scramble address mid-burst; must be ignored
                    req[i] = 1'b0;
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            if (req == '0 && gnt == '0 && q.size() == 0 && !active) finished = 1;
        end
        check("round_done", 32'(finished), 32'd1);
    endtask

    initial begin
        logic [N*AW-1:0] a, l;
        bit seen;
        areset     = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_len    = '0;
        mem_rddata = '0;
        repeat (3) @(negedge aclk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_burst_done", 32'(burst_done), 32'd0);
        areset = 1'b0;

        // All four request from release, single-beat bursts
        a = {5'd9, 5'd17, 5'd2, 5'd25};
        run_round(4'b1111, a, '0, 1'b1);

        // Requester 1, address 3, four beats
        a = '0; l = '0;
        a[1*AW +: AW] = 5'd3; l[1*AW +: AW] = 5'd3;
        run_round(4'b0010, a, l, 1'b1);

        // Requester 0 wrapping past the top of the address space
        a = '0; l = '0;
        a[0 +: AW] = 5'd30; l[0 +: AW] = 5'd3;
        run_round(4'b0001, a, l, 1'b1);

        // ptr now 1: requester 2 must beat requester 0
        a = '0; l = '0;
        a[0 +: AW] = 5'd12; l[0 +: AW] = 5'd1;
        a[2*AW +: AW] = 5'd20; l[2*AW +: AW] = 5'd2;
        run_round(4'b0101, a, l, 1'b1);

        // Random rounds
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                a[i*AW +: AW] = AW'($urandom);
                l[i*AW +: AW] = AW'($urandom_range(0, 7));
            end
            run_round(m, a, l, 1'b0);
        end

        // Reset during beat 2 of a 6-beat burst
        @(negedge aclk);
        req = 4'b0001;
        req_addr[0 +: AW] = 5'd7;
        req_len[0 +: AW]  = 5'd5;
        q.push_back('{2'd0, 5'd7, 5'd5});
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge aclk);
            if (mem_en) seen = 1;
        end
        check("reset_test_started", 32'(seen), 32'd1);
        req = '0;
        @(negedge aclk);
        #2;
        q.delete();
        areset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_burst_done", 32'(burst_done), 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        m_ptr  = 0;
        repeat (8) @(negedge aclk);
        a = '0; l = '0;
        a[3*AW +: AW] = 5'd14; l[3*AW +: AW] = 5'd2;
        run_round(4'b1000, a, l, 1'b1);

        repeat (4) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
